axi_w_router: RTL

Parametrised AXI write-data (W) router that carries beats from one master to NUM_SLAVES slaves. Routing comes from a FIFO of slave IDs pushed at each accepted AW handshake, so multiple writes can be outstanding in order. A write to an unmapped slave ID is absorbed by an internal sink. Sits in the AXI interconnect between the AW decoder/arbiter and the slave W ports.

---
 rtl/axi_w_router_pkg.sv | 20 ++
 rtl/axi_w_router_fifo.sv | 72 +++++++
 rtl/axi_w_router.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/axi_w_router_pkg.sv
// axi_router_pkg: shared types and constants for the AXI W router.
//   AXI_LEN_BITS : width of AWLEN.
//   RT_SID_W     : width of the slave-ID field kept in each route entry. It is
//                  wide enough for any router SID_W up to 8; narrower IDs are
//                  zero-extended on push.
//   route_t      : {sid, len} entry, used when the beat check is built.
//   route_sid_t  : sid-only entry, used when the beat check is not built.
package axi_router_pkg;

   localparam int unsigned AXI_LEN_BITS = 8;
   localparam int unsigned RT_SID_W     = 8;

   typedef logic [RT_SID_W-1:0] route_sid_t;

   typedef struct packed {
      route_sid_t              sid;
      logic [AXI_LEN_BITS-1:0] len;
   } route_t;

endpackage

// File: rtl/axi_w_router_fifo.sv
// axi_route_fifo: generic synchronous FIFO holding outstanding write routes.
// Parameters: DEPTH (power of two, >= 2), entry_t (entry type).
// Ports:
//   clk, rst      clock, synchronous active-high reset (empties the FIFO)
//   push_i        write push_data_i; ignored while full
//   push_data_i   entry to store
//   pop_i         drop the head entry; ignored while empty
//   head_o        oldest entry (undefined while empty)
//   full_o        count_o == DEPTH
//   empty_o       count_o == 0
//   count_o       current occupancy
module axi_route_fifo #(
   parameter int unsigned DEPTH   = 4,
   parameter type         entry_t = logic [7:0],
   localparam int unsigned PTR_W  = $clog2(DEPTH),
   localparam int unsigned CNT_W  = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  entry_t           push_data_i,
   input  logic             pop_i,
   output entry_t           head_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CNT_W-1:0] count_o
);

   entry_t           mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             push_ok, pop_ok;

   assign full_o  = (cnt_q == CNT_W'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;
   assign head_o  = mem_q[rd_ptr_q];

   // Full is judged on the pre-pop count, so a push against a full FIFO is
   // dropped even when a pop happens in the same cycle.
   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push_ok && !pop_ok)      cnt_d = cnt_q + CNT_W'(1);
      else if (pop_ok && !push_ok) cnt_d = cnt_q - CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/axi_w_router.sv
// axi_w_router: routes AXI W beats from one master to NUM_SLAVES slaves.
// The route for each write is queued at its AW handshake; the FIFO head
// selects the slave for the current burst. Unmapped IDs (>= NUM_SLAVES) are
// absorbed by an internal sink that reports decerr after the last beat.
// Optional build macro: AXI_W_BEAT_CHECK_EN (per-entry AWLEN, beat counter,
// counter-driven wlast_s and sticky len_err).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   aw_push/sid/len     AW handshake, target slave, AWLEN
//   aw_full             route FIFO full (AW arbiter must stall)
//   w*_m                master W channel (wready_m is the router's ready)
//   w*_s                per-slave W channels, slice i belongs to slave i
//   decerr              one-cycle pulse after an unmapped burst completes
//   len_err             sticky burst-length mismatch (beat check build only)
//   overflow            sticky, push attempted while full
module axi_w_router #(
   parameter int unsigned NUM_SLAVES = 3,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned STRB_W     = DATA_W / 8,
   parameter int unsigned SID_W      = 2,
   parameter int unsigned DEPTH      = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     aw_push,
   input  logic [SID_W-1:0]         aw_sid,
   input  logic [7:0]               aw_len,
   output logic                     aw_full,
   input  logic [DATA_W-1:0]        wdata_m,
   input  logic [STRB_W-1:0]        wstrb_m,
   input  logic                     wlast_m,
   input  logic                     wvalid_m,
   output logic                     wready_m,
   output logic [NUM_SLAVES*DATA_W-1:0] wdata_s,
   output logic [NUM_SLAVES*STRB_W-1:0] wstrb_s,
   output logic [NUM_SLAVES-1:0]    wlast_s,
   output logic [NUM_SLAVES-1:0]    wvalid_s,
   input  logic [NUM_SLAVES-1:0]    wready_s,
   output logic                     decerr,
`ifdef AXI_W_BEAT_CHECK_EN
   output logic                     len_err,
`endif
   output logic                     overflow
);
   import axi_router_pkg::*;

   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

`ifdef AXI_W_BEAT_CHECK_EN
   typedef route_t ent_t;
`else
   typedef route_sid_t ent_t;
`endif

   ent_t                  push_ent, head_ent;
   route_sid_t            head_sid;
   logic                  fifo_full, fifo_empty, route_vld;
   logic [CNT_W-1:0]      unused_fifo_cnt;
   logic [NUM_SLAVES-1:0] sel_oh;
   logic                  head_mapped, beat_acc, beat_last, pop;
   logic                  decerr_q, decerr_d;
   logic                  overflow_q, overflow_d;

`ifdef AXI_W_BEAT_CHECK_EN
   always_comb begin
      push_ent.sid = route_sid_t'(aw_sid);
      push_ent.len = aw_len;
      head_sid     = head_ent.sid;
   end
`else
   logic [7:0] unused_aw_len;
   assign unused_aw_len = aw_len;
   assign push_ent      = route_sid_t'(aw_sid);
   assign head_sid      = head_ent;
`endif

   axi_route_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (ent_t)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (aw_push),
      .push_data_i (push_ent),
      .pop_i       (pop),
      .head_o      (head_ent),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .count_o     (unused_fifo_cnt)
   );

   assign aw_full   = fifo_full;
   assign route_vld = ~fifo_empty;

   // Route selection is purely combinational from the registered head, so a
   // beat is forwarded in the same cycle it is presented.
   always_comb begin
      sel_oh  = '0;
      wstrb_s = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         sel_oh[i] = route_vld & (head_sid == route_sid_t'(i));
         if (sel_oh[i]) wstrb_s[i*STRB_W +: STRB_W] = wstrb_m;
      end
   end

   assign head_mapped = |sel_oh;
   // Unmapped head: sink accepts everything.
   assign wready_m    = route_vld & (head_mapped ? |(sel_oh & wready_s) : 1'b1);
   assign wvalid_s    = sel_oh & {NUM_SLAVES{wvalid_m}};
   assign wdata_s     = {NUM_SLAVES{wdata_m}};
   assign beat_acc    = wvalid_m & wready_m;
   assign pop         = beat_acc & beat_last;

`ifdef AXI_W_BEAT_CHECK_EN
   // Down-counter of beats remaining in the head burst. rem_vld_q is clear
   // until the head's first beat, so the count comes straight from the entry.
   logic [AXI_LEN_BITS-1:0] rem_q, rem_d, rem_cur;
   logic                    rem_vld_q, rem_vld_d;
   logic                    len_err_q, len_err_d;

   always_comb begin
      rem_cur   = rem_vld_q ? rem_q : head_ent.len;
      beat_last = route_vld & (rem_cur == '0);
      rem_d     = rem_q;
      rem_vld_d = rem_vld_q;
      len_err_d = len_err_q;
      if (beat_acc) begin
         if (beat_last) begin
            rem_vld_d = 1'b0;
         end else begin
            rem_d     = rem_cur - AXI_LEN_BITS'(1);
            rem_vld_d = 1'b1;
         end
         if (wlast_m != beat_last) len_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rem_q     <= '0;
         rem_vld_q <= 1'b0;
         len_err_q <= 1'b0;
      end else begin
         rem_q     <= rem_d;
         rem_vld_q <= rem_vld_d;
         len_err_q <= len_err_d;
      end
   end

   assign wlast_s = {NUM_SLAVES{beat_last}};
   assign len_err = len_err_q;
`else
   assign beat_last = wlast_m;
   assign wlast_s   = {NUM_SLAVES{wlast_m}};
`endif

   always_comb begin
      decerr_d   = pop & ~head_mapped;
      overflow_d = overflow_q | (aw_push & fifo_full);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         decerr_q   <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         decerr_q   <= decerr_d;
         overflow_q <= overflow_d;
      end
   end

   assign decerr   = decerr_q;
   assign overflow = overflow_q;

endmodule
